// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: coin-started fill/wash/rinse/spin sequencer driving the minute timer
module wash_cycle_controller #(
    parameter logic [2:0] FILL_MIN  = 3'd2,
    parameter logic [2:0] WASH_MIN  = 3'd5,
    parameter logic [2:0] RINSE_MIN = 3'd2,
    parameter logic [2:0] SPIN_MIN  = 3'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic       double_wash,
    input  logic       timer_pause,
    input  logic [2:0] timer_elapsed_minutes,
    output logic       run_timer,
    output logic       timer_restart,
    output logic [2:0] state_code,
    output logic       wash_done
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILLING  = 3'd1,
        WASHING  = 3'd2,
        RINSING  = 3'd3,
        SPINNING = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic       second_pass, second_pass_nx;
    logic       dw_latched, dw_latched_nx;
    logic       wash_done_nx;
    logic [2:0] dur;
    logic       phase_done;

    assign dur = state == FILLING ? FILL_MIN :
                 state == WASHING ? WASH_MIN :
                 state == RINSING ? RINSE_MIN : SPIN_MIN;
    // the stale elapsed value seen during the restart pulse is masked; >= covers overshoot
    assign phase_done = !timer_restart && timer_elapsed_minutes >= dur;
    assign run_timer  = state != IDLE && !(state == SPINNING && timer_pause);
    assign state_code = state;

    // next-state and programme bookkeeping
    always_comb begin
        state_nx       = state;
        second_pass_nx = second_pass;
        dw_latched_nx  = dw_latched;
        wash_done_nx   = wash_done;
        case (state)
            IDLE: if (coin_in) begin
                state_nx       = FILLING;
                dw_latched_nx  = double_wash;
                second_pass_nx = 1'b0;
                wash_done_nx   = 1'b0;
            end
            FILLING: if (phase_done) state_nx = WASHING;
            WASHING: if (phase_done) state_nx = RINSING;
            RINSING: if (phase_done) begin
                if (dw_latched && !second_pass) begin
                    state_nx       = WASHING;
                    second_pass_nx = 1'b1;
                end else begin
                    state_nx = SPINNING;
                end
            end
            SPINNING: if (phase_done) begin
                state_nx     = IDLE;
                wash_done_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register; restart is held in IDLE and pulses once on every phase entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer_restart <= 1'b1;
            wash_done     <= 1'b0;
            second_pass   <= 1'b0;
            dw_latched    <= 1'b0;
        end else begin
            state         <= state_nx;
            timer_restart <= state_nx == IDLE || state_nx != state;
            wash_done     <= wash_done_nx;
            second_pass   <= second_pass_nx;
            dw_latched    <= dw_latched_nx;
        end
    end
endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb_wash_cycle_controller: programme-list reference model with a small bench minute timer
module tb_wash_cycle_controller;
    localparam int CPM = 3;

    logic       clk, rst, coin_in, double_wash, timer_pause;
    logic [2:0] timer_elapsed_minutes;
    logic       run_timer, timer_restart, wash_done;
    logic [2:0] state_code;

    wash_cycle_controller dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .double_wash(double_wash),
        .timer_pause(timer_pause), .timer_elapsed_minutes(timer_elapsed_minutes),
        .run_timer(run_timer), .timer_restart(timer_restart),
        .state_code(state_code), .wash_done(wash_done)
    );

    int vectors = 0, errs = 0;
    bit chk_en = 0;
    int prog [6] = '{0, 0, 0, 0, 0, 0};
    int plen = 0, pos = -1;
    bit fresh = 1, done_m = 0;
    int t_min = 0, t_sub = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int dur_of(input int ph);
        return ph == 1 ? 2 : ph == 2 ? 5 : ph == 3 ? 2 : 1;
    endfunction

    // one clock: apply inputs, then advance bench timer and programme model at the edge
    task automatic tick(input bit c, input bit d, input bit p, input bit r, input int sv);
        int e;
        e = sv >= 0 ? sv : t_min;
        coin_in = c; double_wash = d; timer_pause = p; rst = r;
        timer_elapsed_minutes = 3'(e);
        @(posedge clk);
        if (fresh) begin
            t_min = 0; t_sub = 0;
        end else if (pos >= 0 && !(prog[pos] == 4 && p)) begin
            t_sub++;
            if (t_sub == CPM) begin
                t_sub = 0;
                if (t_min < 7) t_min++;
            end
        end
        if (r) begin
            pos = -1; fresh = 1; done_m = 0;
        end else if (pos < 0) begin
            if (c) begin
                if (d) prog = '{1, 2, 3, 2, 3, 4};
                else   prog = '{1, 2, 3, 4, 0, 0};
                plen = d ? 6 : 4;
                pos = 0;
                done_m = 0;
            end
            fresh = 1;
        end else if (!fresh && e >= dur_of(prog[pos])) begin
            pos++;
            fresh = 1;
            if (pos == plen) begin
                pos = -1;
                done_m = 1;
            end
        end else begin
            fresh = 0;
        end
        #2;
    endtask

    task automatic lit(input string nm, input int got, input int want);
        vectors++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        int ec, er;
        #1;
        if (chk_en) begin
            ec = pos < 0 ? 0 : prog[pos];
            er = (pos >= 0 && !(ec == 4 && timer_pause)) ? 1 : 0;
            vectors++;
            if ({state_code, timer_restart, run_timer, wash_done} !==
                {3'(ec), fresh, er[0], done_m}) begin
                errs++;
                $display("FAIL cycle t=%0t: got code=%0d restart=%b run=%b done=%b want code=%0d restart=%b run=%0d done=%b",
                         $time, state_code, timer_restart, run_timer, wash_done, ec, fresh, er, done_m);
            end
        end
    end

    // full programme from a coin; pmode 1 pauses spin for 5 cycles, pmode 2 pauses through washing
    task automatic run_prog(input bit dw, input int pmode, input int want_n, input int want_seq, input string nm);
        int n, seq, last, sc, guard, cb;
        bit p;
        n = 0; seq = 0; last = 0; sc = 0; guard = 0;
        tick(1, dw, 0, 0, -1);
        while (state_code != 0 && guard < 400) begin
            n++;
            if (int'(state_code) != last) begin
                seq = (seq << 4) | int'(state_code);
                last = int'(state_code);
            end
            if (state_code == 4) sc++;
            p = (pmode == 1 && state_code == 4 && sc >= 2 && sc <= 6) || (pmode == 2 && state_code == 2);
            cb = int'(state_code);
            tick(0, !dw, p, 0, -1);
            if (p && int'(state_code) == cb) lit({nm, "_run"}, int'(run_timer), pmode == 1 ? 0 : 1);
            guard++;
        end
        lit({nm, "_cycles"}, n, want_n);
        lit({nm, "_seq"}, seq, want_seq);
        lit({nm, "_done"}, int'(wash_done), 1);
    endtask

    initial begin
        int g;
        bit pz;
        tick(0, 0, 0, 1, -1);
        tick(0, 0, 0, 1, -1);
        chk_en = 1;
        repeat (20) begin
            tick(0, 1'($urandom), 1'($urandom), 0, int'($urandom_range(0, 7)));
            lit("idle_code", int'(state_code), 0);
            lit("idle_restart", int'(timer_restart), 1);
            lit("idle_run", int'(run_timer), 0);
            lit("idle_done", int'(wash_done), 0);
        end
        run_prog(0, 0, 38, 'h1234, "single");
        tick(0, 0, 0, 0, -1);
        lit("done_hold", int'(wash_done), 1);
        run_prog(1, 0, 63, 'h123234, "double");
        run_prog(0, 1, 43, 'h1234, "spin_pause");
        run_prog(0, 2, 38, 'h1234, "wash_pause");
        tick(1, 0, 0, 0, -1);
        lit("coin_clears_done", int'(wash_done), 0);
        tick(0, 0, 0, 0, 7);
        lit("fill_pulse_masked", int'(state_code), 1);
        tick(0, 0, 0, 0, 5);
        lit("fill_overshoot", int'(state_code), 2);
        tick(0, 0, 0, 0, 2);
        lit("wash_pulse_masked", int'(state_code), 2);
        g = 0;
        while (state_code != 3 && g < 100) begin
            tick(0, 0, 0, 0, -1);
            g++;
        end
        lit("reach_rinse", int'(state_code), 3);
        tick(0, 0, 0, 1, -1);
        lit("rst_code", int'(state_code), 0);
        lit("rst_restart", int'(timer_restart), 1);
        lit("rst_done", int'(wash_done), 0);
        run_prog(0, 0, 38, 'h1234, "after_rst");
        pz = 0;
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) pz = !pz;
            tick($urandom_range(0, 3) == 0, 1'($urandom), pz, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 24) == 0 ? int'($urandom_range(0, 7)) : -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
